// File: rtl/mips16_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// mips16_ctrl_pkg : state, opcode and datapath-select encodings.   Rev 1.0
// ============================================================================
package mips16_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_START    = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC_R   = 4'd3,
    ST_WB_R     = 4'd4,
    ST_EXEC_I   = 4'd5,
    ST_WB_I     = 4'd6,
    ST_MEM_ADDR = 4'd7,
    ST_MEM_RD   = 4'd8,
    ST_WB_MEM   = 4'd9,
    ST_MEM_WR   = 4'd10,
    ST_BRANCH   = 4'd11,
    ST_HALT     = 4'd12
  } state_t;

  localparam logic [3:0] OP_R0   = 4'b0000;
  localparam logic [3:0] OP_R1   = 4'b0001;
  localparam logic [3:0] OP_R2   = 4'b0010;
  localparam logic [3:0] OP_R3   = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_LW   = 4'b0101;
  localparam logic [3:0] OP_SW   = 4'b0110;
  localparam logic [3:0] OP_R7   = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_TWO    = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

  typedef struct packed {
    logic       pc_en;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       halted;
  } ctrl_t;

  function automatic logic is_rtype(input logic [3:0] op);
    return (op == OP_R0) || (op == OP_R1) || (op == OP_R2) ||
           (op == OP_R3) || (op == OP_R7);
  endfunction

  function automatic logic is_known_op(input logic [3:0] op);
    return is_rtype(op) || (op == OP_ADDI) || (op == OP_LW) ||
           (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips16_ctrl_decode.sv
`default_nettype none
// ============================================================================
// mips16_ctrl_decode : state + qualifiers -> datapath control vector. Rev 1.0
// ============================================================================
module mips16_ctrl_decode
  import mips16_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  state_t     state,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_TWO;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_en     = mem_ready;
      end
      ST_DECODE: begin
        ctrl.alu_src_b  = SRCB_IMM_SH;
        ctrl.alu_op     = ALU_ADD;
        // An unknown opcode retires right here when it is treated as a NOP.
        ctrl.instr_done = !ILLEGAL_HALT && !is_known_op(opcode);
      end
      ST_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
      end
      ST_WB_R: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ST_EXEC_I, ST_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      ST_WB_I: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ST_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.ior_d    = 1'b1;
      end
      ST_WB_MEM: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ST_MEM_WR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.ior_d      = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRCB_B;
        ctrl.alu_op     = ALU_SUB;
        ctrl.pc_source  = PCSRC_ALUOUT;
        ctrl.pc_en      = zero;
        ctrl.instr_done = 1'b1;
      end
      ST_HALT: ctrl.halted = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mips16_multicycle_control.sv
`default_nettype none
// ============================================================================
// mips16_multicycle_control : multicycle MIPS16 control FSM.         Rev 1.0
// ============================================================================
module mips16_multicycle_control
  import mips16_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       ior_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       halted,
  output logic [3:0] state
);

  state_t state_q, state_d;
  ctrl_t  ctrl;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_START;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_START:  state_d = ST_FETCH;
      ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        if (is_rtype(opcode))                         state_d = ST_EXEC_R;
        else if (opcode == OP_ADDI)                   state_d = ST_EXEC_I;
        else if (opcode == OP_LW || opcode == OP_SW)  state_d = ST_MEM_ADDR;
        else if (opcode == OP_BEQ)                    state_d = ST_BRANCH;
        else state_d = ILLEGAL_HALT ? ST_HALT : ST_FETCH;
      end
      ST_EXEC_R:   state_d = ST_WB_R;
      ST_WB_R:     state_d = ST_FETCH;
      ST_EXEC_I:   state_d = ST_WB_I;
      ST_WB_I:     state_d = ST_FETCH;
      ST_MEM_ADDR: state_d = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD:   if (mem_ready) state_d = ST_WB_MEM;
      ST_WB_MEM:   state_d = ST_FETCH;
      ST_MEM_WR:   if (mem_ready) state_d = ST_FETCH;
      ST_BRANCH:   state_d = ST_FETCH;
      ST_HALT:     state_d = ST_HALT;
      default:     state_d = ST_START;
    endcase
  end

  mips16_ctrl_decode #(
    .ILLEGAL_HALT (ILLEGAL_HALT)
  ) u_decode (
    .state     (state_q),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign pc_en      = ctrl.pc_en;
  assign ior_d      = ctrl.ior_d;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign ir_write   = ctrl.ir_write;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_write  = ctrl.reg_write;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign pc_source  = ctrl.pc_source;
  assign instr_done = ctrl.instr_done;
  assign halted     = ctrl.halted;
  assign state      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_mips16_multicycle_control.sv
`default_nettype none
// ============================================================================
// tb_mips16_multicycle_control : table-driven check of the control FSM. Rev 1.0
// ============================================================================
module tb_mips16_multicycle_control;

  // Output vector field order:
  // pc_en ior_d mem_read mem_write ir_write reg_dst mem_to_reg reg_write
  // alu_src_a alu_src_b[2] alu_op[2] pc_source[2] instr_done halted
  localparam logic [16:0] E_ZERO  = 17'b0_0_0_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [16:0] E_FRDY  = 17'b1_0_1_0_1_0_0_0_0_01_00_00_0_0;
  localparam logic [16:0] E_FSTL  = 17'b0_0_1_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [16:0] E_DEC   = 17'b0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [16:0] E_DECN  = 17'b0_0_0_0_0_0_0_0_0_11_00_00_1_0;
  localparam logic [16:0] E_EXR   = 17'b0_0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [16:0] E_WBR   = 17'b0_0_0_0_0_1_0_1_0_00_00_00_1_0;
  localparam logic [16:0] E_EXI   = 17'b0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [16:0] E_WBI   = 17'b0_0_0_0_0_0_0_1_0_00_00_00_1_0;
  localparam logic [16:0] E_MRD   = 17'b0_1_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [16:0] E_WBM   = 17'b0_0_0_0_0_0_1_1_0_00_00_00_1_0;
  localparam logic [16:0] E_MWS   = 17'b0_1_0_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [16:0] E_MWR   = 17'b0_1_0_1_0_0_0_0_0_00_00_00_1_0;
  localparam logic [16:0] E_BR1   = 17'b1_0_0_0_0_0_0_0_1_00_01_01_1_0;
  localparam logic [16:0] E_BR0   = 17'b0_0_0_0_0_0_0_0_1_00_01_01_1_0;
  localparam logic [16:0] E_HALT  = 17'b0_0_0_0_0_0_0_0_0_00_00_00_0_1;

  typedef struct {
    logic        rst;
    logic [3:0]  op;
    logic        z;
    logic        rdy;
    logic [3:0]  exp_state;
    logic [16:0] exp_out;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset, zero, mem_ready;
  logic [3:0] opcode;

  logic       pc_en1, ior_d1, mem_read1, mem_write1, ir_write1, reg_dst1;
  logic       mem_to_reg1, reg_write1, alu_src_a1, instr_done1, halted1;
  logic [1:0] alu_src_b1, alu_op1, pc_source1;
  logic [3:0] state1;

  logic       pc_en2, ior_d2, mem_read2, mem_write2, ir_write2, reg_dst2;
  logic       mem_to_reg2, reg_write2, alu_src_a2, instr_done2, halted2;
  logic [1:0] alu_src_b2, alu_op2, pc_source2;
  logic [3:0] state2;

  logic [16:0] out1;
  assign out1 = {pc_en1, ior_d1, mem_read1, mem_write1, ir_write1, reg_dst1,
                 mem_to_reg1, reg_write1, alu_src_a1, alu_src_b1, alu_op1,
                 pc_source1, instr_done1, halted1};

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  always #5 clock = ~clock;

  mips16_multicycle_control #(.ILLEGAL_HALT(1'b1)) u_dut (
    .clock(clock), .reset(reset), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en1), .ior_d(ior_d1),
    .mem_read(mem_read1), .mem_write(mem_write1), .ir_write(ir_write1),
    .reg_dst(reg_dst1), .mem_to_reg(mem_to_reg1), .reg_write(reg_write1),
    .alu_src_a(alu_src_a1), .alu_src_b(alu_src_b1), .alu_op(alu_op1),
    .pc_source(pc_source1), .instr_done(instr_done1), .halted(halted1),
    .state(state1)
  );

  mips16_multicycle_control #(.ILLEGAL_HALT(1'b0)) u_dut_nop (
    .clock(clock), .reset(reset), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en2), .ior_d(ior_d2),
    .mem_read(mem_read2), .mem_write(mem_write2), .ir_write(ir_write2),
    .reg_dst(reg_dst2), .mem_to_reg(mem_to_reg2), .reg_write(reg_write2),
    .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2), .alu_op(alu_op2),
    .pc_source(pc_source2), .instr_done(instr_done2), .halted(halted2),
    .state(state2)
  );

  function automatic vec_t mk(input logic r, input logic [3:0] op, input logic z,
                              input logic rdy, input logic [3:0] st,
                              input logic [16:0] o);
    vec_t v;
    v.rst = r; v.op = op; v.z = z; v.rdy = rdy; v.exp_state = st; v.exp_out = o;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Drive one cycle of inputs, compare at the falling edge, then advance.
  task automatic apply(input vec_t v, input string tag);
    reset = v.rst; opcode = v.op; zero = v.z; mem_ready = v.rdy;
    @(negedge clock);
    check({tag, " state"}, {28'd0, state1}, {28'd0, v.exp_state});
    check({tag, " outputs"}, {15'd0, out1}, {15'd0, v.exp_out});
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; opcode = 4'd0; zero = 1'b0; mem_ready = 1'b1;
    #1;

    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 4'h0, 0, 1, 4'd0, E_ZERO));
    vecs.push_back(mk(0, 4'h0, 0, 1, 4'd0, E_ZERO));
    // add
    vecs.push_back(mk(0, 4'h0, 0, 1, 4'd1, E_FRDY));
    vecs.push_back(mk(0, 4'h0, 0, 1, 4'd2, E_DEC));
    vecs.push_back(mk(0, 4'h0, 0, 1, 4'd3, E_EXR));
    vecs.push_back(mk(0, 4'h0, 0, 1, 4'd4, E_WBR));
    // lw with three wait states
    vecs.push_back(mk(0, 4'h5, 0, 1, 4'd1, E_FRDY));
    vecs.push_back(mk(0, 4'h5, 0, 1, 4'd2, E_DEC));
    vecs.push_back(mk(0, 4'h5, 0, 1, 4'd7, E_EXI));
    vecs.push_back(mk(0, 4'h5, 0, 0, 4'd8, E_MRD));
    vecs.push_back(mk(0, 4'h5, 0, 0, 4'd8, E_MRD));
    vecs.push_back(mk(0, 4'h5, 0, 0, 4'd8, E_MRD));
    vecs.push_back(mk(0, 4'h5, 0, 1, 4'd8, E_MRD));
    vecs.push_back(mk(0, 4'h5, 0, 1, 4'd9, E_WBM));
    // beq taken / not taken
    vecs.push_back(mk(0, 4'h8, 1, 1, 4'd1, E_FRDY));
    vecs.push_back(mk(0, 4'h8, 1, 1, 4'd2, E_DEC));
    vecs.push_back(mk(0, 4'h8, 1, 1, 4'd11, E_BR1));
    vecs.push_back(mk(0, 4'h8, 0, 1, 4'd1, E_FRDY));
    vecs.push_back(mk(0, 4'h8, 0, 1, 4'd2, E_DEC));
    vecs.push_back(mk(0, 4'h8, 0, 1, 4'd11, E_BR0));
    // addi with a fetch stall
    vecs.push_back(mk(0, 4'h4, 0, 0, 4'd1, E_FSTL));
    vecs.push_back(mk(0, 4'h4, 0, 1, 4'd1, E_FRDY));
    vecs.push_back(mk(0, 4'h4, 0, 1, 4'd2, E_DEC));
    vecs.push_back(mk(0, 4'h4, 0, 1, 4'd5, E_EXI));
    vecs.push_back(mk(0, 4'h4, 0, 1, 4'd6, E_WBI));
    // sw with one wait state
    vecs.push_back(mk(0, 4'h6, 0, 1, 4'd1, E_FRDY));
    vecs.push_back(mk(0, 4'h6, 0, 1, 4'd2, E_DEC));
    vecs.push_back(mk(0, 4'h6, 0, 1, 4'd7, E_EXI));
    vecs.push_back(mk(0, 4'h6, 0, 0, 4'd10, E_MWS));
    vecs.push_back(mk(0, 4'h6, 0, 1, 4'd10, E_MWR));
    // R-type opcode 0111
    vecs.push_back(mk(0, 4'h7, 0, 1, 4'd1, E_FRDY));
    vecs.push_back(mk(0, 4'h7, 0, 1, 4'd2, E_DEC));
    vecs.push_back(mk(0, 4'h7, 0, 1, 4'd3, E_EXR));
    vecs.push_back(mk(0, 4'h7, 0, 1, 4'd4, E_WBR));
    // illegal opcode: sticky halt, no memory traffic
    vecs.push_back(mk(0, 4'hF, 0, 1, 4'd1, E_FRDY));
    vecs.push_back(mk(0, 4'hF, 0, 1, 4'd2, E_DEC));
    for (int i = 0; i < 10; i++) vecs.push_back(mk(0, 4'h0, 0, 1, 4'd12, E_HALT));
    vecs.push_back(mk(1, 4'h0, 0, 1, 4'd0, E_ZERO));
    vecs.push_back(mk(0, 4'h0, 0, 1, 4'd0, E_ZERO));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Reset while sw is stalled in MEM_WR must drop mem_write before the next edge.
    apply(mk(0, 4'h6, 0, 1, 4'd1, E_FRDY), "sw_rst fetch");
    apply(mk(0, 4'h6, 0, 1, 4'd2, E_DEC),  "sw_rst decode");
    apply(mk(0, 4'h6, 0, 1, 4'd7, E_EXI),  "sw_rst addr");
    mem_ready = 1'b0;
    @(negedge clock);
    check("sw_rst mem_write before reset", {31'd0, mem_write1}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("sw_rst mem_write after reset", {31'd0, mem_write1}, 32'd0);
    check("sw_rst state after reset", {28'd0, state1}, 32'd0);
    check("sw_rst outputs after reset", {15'd0, out1}, {15'd0, E_ZERO});
    @(posedge clock);
    #1;
    apply(mk(0, 4'h0, 0, 1, 4'd0, E_ZERO), "sw_rst release");

    // Illegal opcode treated as NOP on the second instance.
    reset = 1'b0; opcode = 4'hF; mem_ready = 1'b1;
    @(negedge clock);
    check("nop fetch state", {28'd0, state2}, 32'd1);
    @(posedge clock); #1;
    @(negedge clock);
    check("nop decode state", {28'd0, state2}, 32'd2);
    check("nop decode instr_done", {31'd0, instr_done2}, 32'd1);
    check("nop decode halted", {31'd0, halted2}, 32'd0);
    @(posedge clock); #1;
    @(negedge clock);
    check("nop back to fetch", {28'd0, state2}, 32'd1);
    check("nop fetch mem_read", {31'd0, mem_read2}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
